// File: rtl/uart_transmit.sv
// rtl/uart_transmit.sv - 8N1 UART transmitter with valid/ready byte intake
// Every output is registered from next-state so tx never glitches.
module uart_transmit #(
  parameter int CLK_FREQ = 4_992_000,
  parameter int BAUD     = 9600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] dataIn,
  input  logic       send_valid,
  output logic       send_ready,
  output logic       tx,
  output logic       busy,
  output logic       finished_send
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_divider
    $error("uart_transmit: CLK_FREQ / BAUD must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             fin_q, fin_d;
  logic             bit_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    fin_d    = 1'b0;
    bit_done = (cnt_q == CNT_MAX);

    case (state_q)
      S_IDLE: begin
        if (send_valid && ready_q) begin
          shift_d = dataIn;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          fin_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Line level follows the state being entered, so it lands on the same edge.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[idx_d];
      default: tx_d = 1'b1;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  assign send_ready    = ready_q;
  assign tx            = tx_q;
  assign busy          = busy_q;
  assign finished_send = fin_q;

endmodule

// File: tb/tb_uart_transmit.sv
// tb/tb_uart_transmit.sv - directed bench for uart_transmit at default and 4-clock dividers
module tb_uart_transmit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [7:0] din_a, din_b;
  logic       val_a, val_b;
  logic       rdy_a, tx_a, busy_a, fin_a;
  logic       rdy_b, tx_b, busy_b, fin_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  uart_transmit dut_a (
    .clock(clock), .reset(reset), .dataIn(din_a), .send_valid(val_a),
    .send_ready(rdy_a), .tx(tx_a), .busy(busy_a), .finished_send(fin_a)
  );

  uart_transmit #(.CLK_FREQ(40), .BAUD(10)) dut_b (
    .clock(clock), .reset(reset), .dataIn(din_b), .send_valid(val_b),
    .send_ready(rdy_b), .tx(tx_b), .busy(busy_b), .finished_send(fin_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic g_tx(input int sel);   return sel ? tx_b   : tx_a;   endfunction
  function automatic logic g_rdy(input int sel);  return sel ? rdy_b  : rdy_a;  endfunction
  function automatic logic g_busy(input int sel); return sel ? busy_b : busy_a; endfunction
  function automatic logic g_fin(input int sel);  return sel ? fin_b  : fin_a;  endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel != 0) begin val_b = v; din_b = d; end
    else          begin val_a = v; din_a = d; end
  endtask

  // Presents a byte mid-cycle; returns the handshake cycle index.
  task automatic start_send(input int sel, input logic [7:0] b, output int t0);
    @(negedge clock);
    drive(sel, 1'b1, b);
    chk("ready before handshake", {31'd0, g_rdy(sel)}, 32'd1);
    t0 = cyc;
    @(posedge clock);
  endtask

  // Checks every cycle of one frame against the expected line waveform.
  task automatic check_frame(input int sel, input logic [7:0] b, input logic hold,
                             input logic [7:0] nextd, input string tag,
                             output int start_cyc);
    int         c;
    int         bad[10];
    int         status_bad;
    int         bitn;
    logic       expb;
    logic [7:0] rx;
    c          = (sel != 0) ? 4 : 520;
    status_bad = 0;
    rx         = 8'h00;
    start_cyc  = 0;
    for (int i = 0; i < 10; i++) bad[i] = 0;
    for (int k = 0; k < 10 * c; k++) begin
      @(negedge clock);
      if (k == 0) begin
        start_cyc = cyc;
        drive(sel, hold, nextd);
      end
      bitn = k / c;
      expb = (bitn == 0) ? 1'b0 : (bitn == 9) ? 1'b1 : b[bitn-1];
      if (g_tx(sel) !== expb) bad[bitn]++;
      if ((k % c) == (c / 2) && bitn >= 1 && bitn <= 8) rx[bitn-1] = g_tx(sel);
      if (g_fin(sel) !== 1'b0 || g_busy(sel) !== 1'b1 || g_rdy(sel) !== 1'b0) status_bad++;
    end
    for (int i = 0; i < 10; i++) chk($sformatf("%s bit%0d bad cycles", tag, i), bad[i], 0);
    chk({tag, " received byte"}, {24'd0, rx}, {24'd0, b});
    chk({tag, " in-frame status bad cycles"}, status_bad, 0);
    @(negedge clock);
    chk({tag, " finished_send"}, {31'd0, g_fin(sel)}, 32'd1);
    chk({tag, " busy at finish"}, {31'd0, g_busy(sel)}, 32'd0);
    chk({tag, " ready at finish"}, {31'd0, g_rdy(sel)}, 32'd1);
    chk({tag, " finish latency"}, cyc - start_cyc + 1, 10 * c + 1);
  endtask

  initial begin
    int t0, t1, s1, s2, fin_bad;
    reset = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);

    // Reset: two cycles held, then idle with send_valid low
    @(negedge clock);
    chk("reset tx", {31'd0, tx_a}, 32'd1);
    chk("reset ready", {31'd0, rdy_a}, 32'd1);
    chk("reset busy", {31'd0, busy_a}, 32'd0);
    chk("reset fin", {31'd0, fin_a}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("idle tx", {31'd0, tx_a}, 32'd1);
    chk("idle ready", {31'd0, rdy_a}, 32'd1);
    chk("idle busy", {31'd0, busy_a}, 32'd0);
    chk("idle fin", {31'd0, fin_a}, 32'd0);
    chk("small idle tx", {31'd0, tx_b}, 32'd1);

    // Single frame 0x0F, dataIn scrambled during the frame
    start_send(0, 8'h0F, t0);
    check_frame(0, 8'h0F, 1'b0, 8'hF0, "f0F", s1);
    chk("f0F finish cycle", cyc - t0, 5201);
    @(negedge clock);
    chk("f0F single pulse", {31'd0, fin_a}, 32'd0);
    chk("f0F no resend", {31'd0, busy_a}, 32'd0);

    // Loopback-style decode of three bytes in order
    start_send(0, 8'hA5, t0);
    check_frame(0, 8'hA5, 1'b0, 8'h5A, "fA5", s1);
    start_send(0, 8'h00, t0);
    check_frame(0, 8'h00, 1'b0, 8'hFF, "f00", s1);
    start_send(0, 8'hFF, t0);
    check_frame(0, 8'hFF, 1'b0, 8'h00, "fFF", s1);

    // Back-to-back: valid stays high, second handshake in the finish cycle
    start_send(0, 8'h55, t0);
    check_frame(0, 8'h55, 1'b1, 8'h3C, "b2b1", s1);
    @(posedge clock);
    check_frame(0, 8'h3C, 1'b0, 8'hAA, "b2b2", s2);
    chk("b2b second start offset", s2 - t0, 5202);

    // Reset during data bit 3 of 0x81
    start_send(0, 8'h81, t0);
    @(negedge clock);
    drive(0, 1'b0, 8'h00);
    repeat (4 * 520 + 260) @(negedge clock);
    chk("mid tx before reset", {31'd0, tx_a}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid reset tx", {31'd0, tx_a}, 32'd1);
    chk("mid reset ready", {31'd0, rdy_a}, 32'd1);
    chk("mid reset busy", {31'd0, busy_a}, 32'd0);
    fin_bad = 0;
    for (int k = 0; k < 600; k++) begin
      if (fin_a !== 1'b0 || tx_a !== 1'b1) fin_bad++;
      @(negedge clock);
    end
    chk("mid reset no finish", fin_bad, 0);
    start_send(0, 8'h42, t1);
    check_frame(0, 8'h42, 1'b0, 8'hBD, "f42", s1);

    // Small divider, CLKS_PER_BIT = 4
    start_send(1, 8'hC3, t0);
    check_frame(1, 8'hC3, 1'b0, 8'h3C, "sC3", s1);
    chk("sC3 finish cycle", cyc - t0, 41);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_transmit.md
# uart_transmit

8N1 UART transmitter that serialises one byte at a time onto a single `tx` line. It is the sending stage that drives `uart_receive`'s `rx` input, both for board-level links and for the loopback bench. It uses the same clock/baud parameterisation as `uart_receive`, so both ends agree on bit period. Bytes enter through a valid/ready handshake. A one-cycle completion pulse marks the end of each frame.

## Interface
- `CLK_FREQ`, default 4_992_000: input clock frequency in Hz.
- `BAUD`, default 9600: line rate in bits/s.
- `CLKS_PER_BIT`, derived as `CLK_FREQ / BAUD` (integer division; 520 at defaults). Must be ≥ 2; elaboration error otherwise.

Ports:
- `clock`  input  1  system clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `dataIn`  input  8  byte to transmit; sampled only on handshake.
- `send_valid`  input  1  requester has a byte on `dataIn`.
- `send_ready`  output  1  transmitter can accept a byte this cycle.
- `tx`  output  1  serial line; idle high; registered output.
- `busy`  output  1  high from the cycle after acceptance through the last stop-bit cycle.
- `finished_send`  output  1  one-cycle pulse when a frame has fully left the line.

## Operation
- **States:** IDLE, START, DATA, STOP.
- **Registers:**
  - bit-period counter, `$clog2(CLKS_PER_BIT)` bits, counts 0..CLKS_PER_BIT-1.
  - 3-bit data index, 0..7.
  - 8-bit shift register.
- **Reset values:** state IDLE, `tx`=1, `send_ready`=1, `busy`=0, `finished_send`=0, counter=0, index=0, shift register=0.
- **IDLE:**
  - `send_ready`=1, `tx`=1.
  - On `send_valid && send_ready`: capture `dataIn` into the shift register, clear the counter, go to START.
  - `send_valid` low: remain in IDLE, no output change.
- **START:**
  - `tx`=0 for exactly CLKS_PER_BIT cycles.
  - When the counter reaches CLKS_PER_BIT-1: clear it, set index=0, go to DATA.
- **DATA:**
  - `tx` = shift-register bit[index], LSB first. Each bit is held CLKS_PER_BIT cycles.
  - At counter terminal count with index<7: increment index, clear the counter.
  - At counter terminal count with index==7: go to STOP.
- **STOP:**
  - `tx`=1 for CLKS_PER_BIT cycles.
  - At terminal count: go to IDLE and assert `finished_send` for the following single cycle.
- **Input isolation:** changes on `dataIn` or `send_valid` outside IDLE are ignored. The shift register is loaded only on the handshake cycle.
- **Outputs:** `send_ready` is low in START/DATA/STOP. `busy` equals (state != IDLE).
- **Reset mid-frame:**
  - On the next edge: state IDLE, `tx`=1, `send_ready`=1.
  - No `finished_send`; the partial frame is abandoned.
  - Reset takes priority over a simultaneous handshake.
- **Counter wrap:** the counter never exceeds CLKS_PER_BIT-1. Index wrap from 7 is never taken, since STOP is entered instead.

## Timing
- **Frame timing:** handshake at edge t (state IDLE, `send_valid`=1).
  - `tx` falls at t+1. Start bit occupies t+1 .. t+CLKS_PER_BIT.
  - Data bit i occupies t+1+(i+1)·CLKS_PER_BIT .. t+(i+2)·CLKS_PER_BIT, for i=0..7.
  - Stop bit occupies t+1+9·CLKS_PER_BIT .. t+10·CLKS_PER_BIT.
- **Completion:** at cycle t+10·CLKS_PER_BIT+1, state is IDLE, `finished_send`=1, `send_ready`=1 and `busy`=0.
- **Back-to-back:** a new handshake is permitted in the `finished_send` cycle. The next start bit then begins one cycle later, so the minimum frame-to-frame spacing is 10·CLKS_PER_BIT+1 cycles.
- **Line timing:** `tx` is glitch-free (registered). Every bit is exactly CLKS_PER_BIT cycles, with no cumulative drift.
- **Latency:** handshake to first `tx` low is 1 cycle. Handshake to `finished_send` is 10·CLKS_PER_BIT+1 cycles (5201 at defaults).

## Test plan
- **Reset:** hold `reset`=1 for 2 cycles, then release. Required: `tx`=1, `send_ready`=1, `busy`=0, `finished_send`=0 during reset and afterwards with `send_valid`=0.
- **Single frame 0x0F at defaults:**
  - `tx` is low for 520 cycles, then the data bits 1,1,1,1,0,0,0,0 at 520 cycles each, then high for 520 cycles.
  - `finished_send` pulses once, exactly 5201 cycles after the handshake.
- **Loopback into `uart_receive` #(4_992_000, 9600):**
  - Send 0xA5, then 0x00, then 0xFF.
  - Receiver `dataOut` must equal each byte in order, with one `finished_read` per byte.
- **Back-to-back:**
  - Keep `send_valid`=1 with 0x55 then 0x3C.
  - The second handshake occurs in the `finished_send` cycle. The second start bit begins 5202 cycles after the first handshake.
  - `dataIn` changes during frame 1 do not corrupt its bits.
- **Reset mid-frame:**
  - Assert `reset` during data bit 3 of 0x81.
  - `tx`=1 on the next edge and no `finished_send`.
  - A following send of 0x42 is transmitted correctly.
- **Small divider:** with CLK_FREQ=40, BAUD=10 (CLKS_PER_BIT=4), send 0xC3. Every bit must last exactly 4 cycles and `finished_send` must occur 41 cycles after the handshake.
